// File: rtl/hssl_tx_framer_pkg.sv
// rtl/hssl_tx_framer_pkg.sv - shared HSSL code words, FSM state encoding and word-wide CRC-16
package hssl_tx_framer_pkg;

   localparam logic [31:0] IDLE_WORD  = 32'h5050_50BC;
   localparam logic [3:0]  IDLE_K     = 4'b0001;
   localparam logic [31:0] CLKC_WORD  = 32'h1C1C_1C1C;
   localparam logic [3:0]  CLKC_K     = 4'b1111;
   localparam logic [31:0] SOF_WORD   = 32'h0000_00FB;
   localparam logic [3:0]  SOF_K      = 4'b0001;
   localparam logic [7:0]  EOF_KCHAR  = 8'hFD;
   localparam logic [3:0]  EOF_K      = 4'b0001;
   localparam logic [3:0]  DATA_K     = 4'b0000;
   localparam logic [15:0] CRC_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC_POLY   = 16'h1021;

   typedef logic [2:0] state_t;
   localparam state_t ST_LINK_DOWN = 3'd0;
   localparam state_t ST_IDLE      = 3'd1;
   localparam state_t ST_SOF       = 3'd2;
   localparam state_t ST_DATA      = 3'd3;
   localparam state_t ST_EOF       = 3'd4;
   localparam state_t ST_CC        = 3'd5;

   // Byte0 goes first on the wire, so it is folded in first, MSB-first within each byte.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int b = 0; b < 4; b++) begin
         for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[b*8 + i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/hssl_tx_framer.sv
// rtl/hssl_tx_framer.sv - HSSL TX framer: SOF/payload/EOF framing, comma idle fill, clock correction
module hssl_tx_framer #(
   parameter int FRAME_WORDS     = 16,
   parameter int CLK_CORR_PERIOD = 4096,
   parameter int CLK_CORR_LEN    = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        tx_reset_done_in,
   input  logic [31:0] data_in,
   input  logic        vld_in,
   input  logic        last_in,
   output logic        rdy_out,
   output logic [31:0] tx_data_out,
   output logic [3:0]  tx_charisk_out,
   output logic        frame_abort_out
);
   import hssl_tx_framer_pkg::*;

   localparam int TW = $clog2(CLK_CORR_PERIOD);

   state_t        state_q, state_d;
   logic          ret_data_q, ret_data_d;
   logic [7:0]    count_q, count_d;
   logic [15:0]   crc_q, crc_d;
   logic [1:0]    cc_cnt_q, cc_cnt_d;
   logic [TW-1:0] cc_timer_q, cc_timer_d;
   logic          cc_pending_q, cc_pending_d;
   logic [31:0]   tx_data_q, tx_data_d;
   logic [3:0]    tx_charisk_q, tx_charisk_d;
   logic          abort_q, abort_d;
   logic          accept, cc_take, cc_wrap;

   assign rdy_out         = tx_reset_done_in & (state_q == ST_DATA) & ~cc_pending_q;
   assign accept          = vld_in & rdy_out;
   assign tx_data_out     = tx_data_q;
   assign tx_charisk_out  = tx_charisk_q;
   assign frame_abort_out = abort_q;
   assign cc_wrap         = (cc_timer_q == TW'(CLK_CORR_PERIOD - 1));

   always_comb begin
      state_d      = state_q;
      ret_data_d   = ret_data_q;
      count_d      = count_q;
      crc_d        = crc_q;
      cc_cnt_d     = cc_cnt_q;
      tx_data_d    = IDLE_WORD;
      tx_charisk_d = IDLE_K;
      abort_d      = 1'b0;
      cc_take      = 1'b0;

      // Losing the link mid-frame drops the frame; the EOF code is never sent for it.
      if (!tx_reset_done_in) begin
         state_d = ST_LINK_DOWN;
         abort_d = (state_q == ST_SOF) || (state_q == ST_DATA) || (state_q == ST_EOF) ||
                   ((state_q == ST_CC) && ret_data_q);
      end else begin
         case (state_q)
            ST_LINK_DOWN: state_d = ST_IDLE;
            ST_IDLE: begin
               if (cc_pending_q) begin
                  state_d    = ST_CC;
                  ret_data_d = 1'b0;
                  cc_cnt_d   = 2'd0;
                  cc_take    = 1'b1;
               end else if (vld_in) begin
                  state_d = ST_SOF;
               end
            end
            ST_SOF: begin
               tx_data_d    = SOF_WORD;
               tx_charisk_d = SOF_K;
               count_d      = 8'd0;
               crc_d        = CRC_INIT;
               state_d      = ST_DATA;
            end
            ST_DATA: begin
               if (accept) begin
                  tx_data_d    = data_in;
                  tx_charisk_d = DATA_K;
                  count_d      = count_q + 8'd1;
                  crc_d        = crc16_word(crc_q, data_in);
                  if (last_in || (count_q == 8'(FRAME_WORDS - 1))) state_d = ST_EOF;
               end else if (cc_pending_q) begin
                  state_d    = ST_CC;
                  ret_data_d = 1'b1;
                  cc_cnt_d   = 2'd0;
                  cc_take    = 1'b1;
               end
            end
            ST_EOF: begin
               tx_data_d    = {crc_q, count_q, EOF_KCHAR};
               tx_charisk_d = EOF_K;
               state_d      = ST_IDLE;
            end
            ST_CC: begin
               tx_data_d    = CLKC_WORD;
               tx_charisk_d = CLKC_K;
               if (cc_cnt_q == 2'(CLK_CORR_LEN - 1)) begin
                  state_d = ret_data_q ? ST_DATA : ST_IDLE;
               end else begin
                  cc_cnt_d = cc_cnt_q + 2'd1;
               end
            end
            default: state_d = ST_LINK_DOWN;
         endcase
      end
   end

   always_comb begin
      cc_timer_d   = cc_timer_q;
      cc_pending_d = cc_pending_q;
      if (!tx_reset_done_in || (state_q == ST_LINK_DOWN)) begin
         cc_timer_d   = '0;
         cc_pending_d = 1'b0;
      end else begin
         cc_timer_d   = cc_wrap ? '0 : cc_timer_q + TW'(1);
         cc_pending_d = cc_wrap | (cc_pending_q & ~cc_take);
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= ST_LINK_DOWN;
         ret_data_q   <= 1'b0;
         count_q      <= 8'd0;
         crc_q        <= CRC_INIT;
         cc_cnt_q     <= 2'd0;
         cc_timer_q   <= '0;
         cc_pending_q <= 1'b0;
         tx_data_q    <= IDLE_WORD;
         tx_charisk_q <= IDLE_K;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ret_data_q   <= ret_data_d;
         count_q      <= count_d;
         crc_q        <= crc_d;
         cc_cnt_q     <= cc_cnt_d;
         cc_timer_q   <= cc_timer_d;
         cc_pending_q <= cc_pending_d;
         tx_data_q    <= tx_data_d;
         tx_charisk_q <= tx_charisk_d;
         abort_q      <= abort_d;
      end
   end

endmodule

// File: tb/tb_hssl_tx_framer.sv
// tb/tb_hssl_tx_framer.sv - randomized self-checking bench for hssl_tx_framer with an output-stream scoreboard
module tb_hssl_tx_framer;

   localparam int FW   = 4;
   localparam int PER  = 16;
   localparam int CLEN = 2;
   localparam logic [31:0] W_IDLE = 32'h5050_50BC;
   localparam logic [31:0] W_CLKC = 32'h1C1C_1C1C;
   localparam logic [31:0] W_SOF  = 32'h0000_00FB;

   typedef struct packed { logic [31:0] d; logic l; } word_t;

   logic        clk = 1'b0;
   logic        rst, link, vld, last;
   logic [31:0] din;
   logic        rdy, abort;
   logic [31:0] txd;
   logic [3:0]  txk;

   int vectors = 0;
   int miscompares = 0;

   // scoreboard state
   word_t       expq[$];
   word_t       w_pop;
   bit          in_frame, exp_eof, prev_acc, prev_rdy, prev_link;
   int          m_cnt, fillers, cc_in_frame, frames_done, aborts, cc_runs, run_len, cyc, last_run_start;
   logic [15:0] m_crc;
   logic [7:0]  m_cnt8;
   int          eof_counts[$];
   logic [15:0] eof_crcs[$];
   int          eof_nonpay[$];

   hssl_tx_framer #(.FRAME_WORDS(FW), .CLK_CORR_PERIOD(PER), .CLK_CORR_LEN(CLEN)) dut (
      .clk_in(clk), .reset_in(rst), .tx_reset_done_in(link), .data_in(din), .vld_in(vld),
      .last_in(last), .rdy_out(rdy), .tx_data_out(txd), .tx_charisk_out(txk), .frame_abort_out(abort)
   );

   always #5 clk = ~clk;

   // byte-at-a-time CCITT CRC, byte0 first
   function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [31:0] w);
      logic [15:0] c;
      logic [7:0]  b;
      c = c_in;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         c = c ^ {b, 8'h00};
         for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         in_frame = 0; exp_eof = 0; prev_acc = 0; run_len = 0; last_run_start = -1;
         prev_rdy = rdy; prev_link = link;
      end else begin
         cyc++;
         if (abort === 1'b1) begin
            vectors++;
            if (prev_link !== 1'b0) begin
               miscompares++;
               $display("FAIL abort_while_link_up: abort=%b link_prev=%b required link_prev=0", abort, prev_link);
            end
            aborts++;
            in_frame = 0; exp_eof = 0; expq.delete();
         end
         if (txd === W_CLKC && txk === 4'hF) begin
            if (run_len == 0) begin
               if (last_run_start >= 0) begin
                  vectors++;
                  if (cyc - last_run_start < PER - 2 || cyc - last_run_start > PER + 2) begin
                     miscompares++;
                     $display("FAIL cc_spacing: got %0d cycles, required %0d..%0d", cyc - last_run_start, PER - 2, PER + 2);
                  end
               end
               last_run_start = cyc;
            end
            run_len++;
            if (in_frame) cc_in_frame++;
         end else if (run_len != 0) begin
            vectors++;
            if (run_len != CLEN) begin
               miscompares++;
               $display("FAIL cc_length: got %0d CLKC words, required %0d", run_len, CLEN);
            end
            cc_runs++;
            run_len = 0;
         end

         if (!prev_link) begin
            last_run_start = -1;
            vectors++;
            if (txd !== W_IDLE || txk !== 4'b0001) begin
               miscompares++;
               $display("FAIL link_down_output: got %h/%b required %h/0001", txd, txk, W_IDLE);
            end
         end else if (prev_acc) begin
            vectors++;
            if (expq.size() == 0 || !in_frame || txk !== 4'b0000 || txd !== expq[0].d) begin
               miscompares++;
               $display("FAIL payload: got %h/%b in_frame=%0d required %h/0000",
                        txd, txk, in_frame, (expq.size() != 0) ? expq[0].d : 32'h0);
            end
            if (expq.size() != 0) begin
               w_pop = expq.pop_front();
               m_crc = ref_crc(m_crc, w_pop.d);
               m_cnt++;
               if (w_pop.l || m_cnt == FW) exp_eof = 1;
            end
         end else if (exp_eof) begin
            vectors++;
            m_cnt8 = m_cnt[7:0];
            if (txk !== 4'b0001 || txd !== {m_crc, m_cnt8, 8'hFD}) begin
               miscompares++;
               $display("FAIL eof: got %h/%b required %h/0001", txd, txk, {m_crc, m_cnt8, 8'hFD});
            end
            eof_counts.push_back(int'(txd[15:8]));
            eof_crcs.push_back(txd[31:16]);
            eof_nonpay.push_back(fillers + cc_in_frame);
            frames_done++;
            in_frame = 0; exp_eof = 0;
         end else if (txk === 4'b0000) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_payload: got %h/0000 required no payload", txd);
         end else if (txd === W_SOF && txk === 4'b0001) begin
            vectors++;
            if (in_frame) begin
               miscompares++;
               $display("FAIL sof_in_frame: got SOF inside open frame, required EOF first");
            end
            in_frame = 1; m_cnt = 0; m_crc = 16'hFFFF; fillers = 0; cc_in_frame = 0;
         end else if (txd === W_IDLE && txk === 4'b0001) begin
            if (in_frame) fillers++;
         end else if (txd === W_CLKC && txk === 4'hF) begin
            vectors++;
            if (prev_rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL cc_rdy: rdy=%b during CC, required 0", prev_rdy);
            end
         end else begin
            vectors++; miscompares++;
            $display("FAIL unknown_word: got %h/%b", txd, txk);
         end

         if (!link) begin
            vectors++;
            if (rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL rdy_link_down: got rdy=%b required 0", rdy);
            end
         end
         prev_acc = (vld === 1'b1) && (rdy === 1'b1);
         if (prev_acc) expq.push_back({din, last});
         prev_rdy  = rdy;
         prev_link = link;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic l);
      bit got;
      got = 0;
      vld = 1; din = d; last = l;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (rdy === 1'b1) got = 1;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL accept_timeout: word %h not accepted, required acceptance within 200 cycles", d);
      end
      @(posedge clk); #1;
      vld = 0; last = 0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(posedge clk); #1;
         if (expq.size() == 0 && !in_frame && !exp_eof) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d words pending in_frame=%0d, required drained", expq.size(), in_frame);
      end
   endtask

   task automatic test_reset();
      rst = 1; link = 0; vld = 0; last = 0; din = '0;
      for (int i = 0; i < 13; i++) begin
         if (i == 3) begin @(posedge clk); #1; rst = 0; end
         @(negedge clk);
         vectors++;
         if (txd !== W_IDLE || txk !== 4'b0001 || rdy !== 1'b0 || abort !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_linkdown[%0d]: got %h/%b rdy=%b abort=%b required %h/0001 rdy=0 abort=0",
                     i, txd, txk, rdy, abort, W_IDLE);
         end
      end
      @(posedge clk); #1; link = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rdy_before_sof[%0d]: got %b required 0", i, rdy);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      int f0;
      f0 = frames_done;
      send_word(32'hDEADBEEF, 1'b1);
      wait_idle();
      vectors++;
      if (frames_done != f0 + 1 || eof_counts[$] != 1 || eof_crcs[$] !== ref_crc(16'hFFFF, 32'hDEADBEEF)) begin
         miscompares++;
         $display("FAIL single_word: frames=%0d count=%0d crc=%h required frames=%0d count=1 crc=%h",
                  frames_done - f0, eof_counts[$], eof_crcs[$], 1, ref_crc(16'hFFFF, 32'hDEADBEEF));
      end
   endtask

   task automatic test_max_split();
      int f0, s;
      f0 = frames_done;
      for (int i = 0; i < 10; i++) send_word($urandom, (i == 9));
      wait_idle();
      s = eof_counts.size();
      vectors++;
      if (frames_done != f0 + 3 || s < 3 || eof_counts[s-3] != 4 || eof_counts[s-2] != 4 || eof_counts[s-1] != 2) begin
         miscompares++;
         $display("FAIL max_split: frames=%0d counts=%0d,%0d,%0d required 3 frames counts 4,4,2",
                  frames_done - f0, (s >= 3) ? eof_counts[s-3] : -1, (s >= 2) ? eof_counts[s-2] : -1,
                  (s >= 1) ? eof_counts[s-1] : -1);
      end
   endtask

   task automatic test_clock_corr();
      int r0, c0, runs, exp_runs;
      r0 = cc_runs; c0 = cyc;
      for (int i = 0; i < 60; i++) send_word($urandom, (i == 59));
      wait_idle();
      runs = cc_runs - r0;
      exp_runs = (cyc - c0) / PER;
      vectors++;
      if (runs < exp_runs - 1 || runs > exp_runs + 1) begin
         miscompares++;
         $display("FAIL cc_rate: got %0d CC runs in %0d cycles, required %0d +/-1", runs, cyc - c0, exp_runs);
      end
   endtask

   task automatic test_abort_relink();
      int a0, f0;
      a0 = aborts; f0 = frames_done;
      send_word($urandom, 1'b0);
      send_word($urandom, 1'b0);
      link = 0;
      repeat (6) begin @(posedge clk); #1; end
      vectors++;
      if (aborts != a0 + 1 || frames_done != f0) begin
         miscompares++;
         $display("FAIL abort: got %0d aborts %0d EOFs, required 1 abort 0 EOFs", aborts - a0, frames_done - f0);
      end
      link = 1;
      repeat (3) begin @(posedge clk); #1; end
      for (int i = 0; i < 3; i++) send_word($urandom, (i == 2));
      wait_idle();
      vectors++;
      if (frames_done != f0 + 1 || eof_counts[$] != 3 || aborts != a0 + 1) begin
         miscompares++;
         $display("FAIL relink_frame: frames=%0d count=%0d aborts=%0d required frames=1 count=3 aborts=1",
                  frames_done - f0, eof_counts[$], aborts - a0);
      end
   endtask

   task automatic test_vld_gap();
      int f0;
      logic [31:0] w[3];
      logic [15:0] c;
      f0 = frames_done;
      for (int i = 0; i < 3; i++) w[i] = $urandom;
      send_word(w[0], 1'b0);
      send_word(w[1], 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      send_word(w[2], 1'b1);
      wait_idle();
      c = 16'hFFFF;
      for (int i = 0; i < 3; i++) c = ref_crc(c, w[i]);
      vectors++;
      if (frames_done != f0 + 1 || eof_counts[$] != 3 || eof_crcs[$] !== c) begin
         miscompares++;
         $display("FAIL gap_frame: frames=%0d count=%0d crc=%h required frames=1 count=3 crc=%h",
                  frames_done - f0, eof_counts[$], eof_crcs[$], c);
      end
      vectors++;
      if (eof_nonpay[$] < 5 || eof_nonpay[$] > 5 + 2 * (CLEN + 1)) begin
         miscompares++;
         $display("FAIL gap_fillers: got %0d non-payload words in frame, required %0d..%0d",
                  eof_nonpay[$], 5, 5 + 2 * (CLEN + 1));
      end
   endtask

   task automatic test_back_to_back();
      int f0, cnt, s;
      int exp_counts[$];
      logic l;
      f0 = frames_done; cnt = 0;
      for (int i = 0; i < 50; i++) begin
         l = (i == 49) || ($urandom_range(0, 3) == 0);
         cnt++;
         if (l || cnt == FW) begin exp_counts.push_back(cnt); cnt = 0; end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send_word($urandom, l);
      end
      wait_idle();
      s = eof_counts.size();
      vectors++;
      if (frames_done - f0 != exp_counts.size()) begin
         miscompares++;
         $display("FAIL b2b_frames: got %0d frames required %0d", frames_done - f0, exp_counts.size());
      end else begin
         for (int i = 0; i < exp_counts.size(); i++) begin
            vectors++;
            if (eof_counts[s - exp_counts.size() + i] != exp_counts[i]) begin
               miscompares++;
               $display("FAIL b2b_count[%0d]: got %0d required %0d", i,
                        eof_counts[s - exp_counts.size() + i], exp_counts[i]);
            end
         end
      end
   endtask

   initial begin
      frames_done = 0; aborts = 0; cc_runs = 0; cyc = 0;
      m_cnt = 0; fillers = 0; cc_in_frame = 0; m_crc = 16'hFFFF;
      test_reset();
      test_single_word();
      test_max_split();
      test_clock_corr();
      test_abort_relink();
      test_vld_gap();
      test_back_to_back();
      vectors++;
      if (aborts != 1) begin
         miscompares++;
         $display("FAIL abort_total: got %0d aborts required 1", aborts);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
